// File: rtl/mul32_seq_ctrl_if.sv
// Operand/product handshake bundle between ALU issue logic and the sequential multiplier.
// master = issue/consumer side, slave = mul32_seq_ctrl.
interface mul32_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  modport master (
    output flush, in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  flush, in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/mul32_seq_ctrl.sv
// Unsigned WIDTH x WIDTH multiply sequenced over one 8x8 array; N*N+1 cycles (+1 with PIPE) from acceptance.
// One op in flight: in_ready only in IDLE; product/out_valid held in DONE until out_ready.
module dadda_multiplier (
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  output logic [15:0] p
);
  assign p = 16'(x) * 16'(y);
endmodule

module mul32_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter bit PIPE  = 1'b0
) (
  input logic             clk,
  input logic             rst_n,
  mul32_seq_ctrl_if.slave mif
);
  localparam int N  = WIDTH / 8;
  localparam int IW = $clog2(N + 1);
  localparam int SW = $clog2(2 * N);
  localparam int AW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, WAIT, DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q, b_q;
  logic [AW-1:0]    acc, add_term;
  logic [IW-1:0]    i_q, j_q;
  logic [7:0]       chunk_a, chunk_b;
  logic [7:0]       op_a, op_b;
  logic [SW-1:0]    op_sh, add_sh;
  logic             op_vld, add_en;
  logic [15:0]      mul_p, add_p;
  logic             issue, accept;

  assign accept = (state == IDLE) && mif.in_valid && !mif.flush;
  // i_q == N marks the drain cycle after the last pair has been issued.
  assign issue  = (state == RUN) && (i_q != IW'(N));

  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int c = 0; c < N; c++) begin
      if (i_q == IW'(c)) chunk_a = a_q[8*c +: 8];
      if (j_q == IW'(c)) chunk_b = b_q[8*c +: 8];
    end
  end

  dadda_multiplier u_mul (
    .x (op_a),
    .y (op_b),
    .p (mul_p)
  );

  generate
    if (PIPE) begin : g_pipe
      logic [15:0]   pp_q;
      logic [SW-1:0] pp_sh;
      logic          pp_vld;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pp_q   <= '0;
          pp_sh  <= '0;
          pp_vld <= 1'b0;
        end else if (mif.flush) begin
          pp_q   <= '0;
          pp_sh  <= '0;
          pp_vld <= 1'b0;
        end else begin
          pp_q   <= mul_p;
          pp_sh  <= op_sh;
          pp_vld <= op_vld;
        end
      end

      assign add_p  = pp_q;
      assign add_sh = pp_sh;
      assign add_en = pp_vld;
    end else begin : g_comb
      assign add_p  = mul_p;
      assign add_sh = op_sh;
      assign add_en = op_vld;
    end
  endgenerate

  assign add_term = AW'(add_p) << {add_sh, 3'b000};

  // Operand registers stay at zero outside RUN so the array does not toggle while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      i_q    <= '0;
      j_q    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      op_sh  <= '0;
      op_vld <= 1'b0;
    end else if (mif.flush) begin
      acc    <= '0;
      i_q    <= '0;
      j_q    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      op_sh  <= '0;
      op_vld <= 1'b0;
    end else begin
      if (accept) begin
        a_q <= mif.a;
        b_q <= mif.b;
        acc <= '0;
        i_q <= '0;
        j_q <= '0;
      end else begin
        if (add_en) acc <= acc + add_term;
        if (issue) begin
          if (j_q == IW'(N - 1)) begin
            j_q <= '0;
            i_q <= i_q + IW'(1);
          end else begin
            j_q <= j_q + IW'(1);
          end
        end
      end
      op_vld <= issue;
      op_a   <= issue ? chunk_a : 8'd0;
      op_b   <= issue ? chunk_b : 8'd0;
      op_sh  <= issue ? (SW'(i_q) + SW'(j_q)) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN:  if (!issue) state_nxt = PIPE ? WAIT : DONE;
      WAIT: state_nxt = DONE;
      DONE: if (mif.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (mif.flush) state_nxt = IDLE;
  end

  assign mif.in_ready  = (state == IDLE);
  assign mif.out_valid = (state == DONE);
  assign mif.busy      = (state != IDLE);
  assign mif.product   = (state == DONE) ? acc : '0;
endmodule
